alu_disp_scan: RTL and testbench
================================

Name: alu_disp_scan

Overview:
- Registered, parametrised ALU with a multiplexed seven-segment output stage, replacing the purely combinational ALU/display path.
- Operands and opcode are captured on a start strobe. Result and flags are registered. The result is shown in hex on DIGITS time-multiplexed digits, driven by an internal scan counter.
- Sits between the board switches/buttons and the shared segment/anode pins.

Parameters:
- N, 8, operand/result width in bits (4..16).
- DIGITS, 4, number of scanned digits; must be at least ceil(N/4).
- SCAN_DIV, 50000, clock cycles each digit stays enabled (at least 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe; captures a, b, op.
- a  in  N  operand A.
- b  in  N  operand B.
- op  in  4  opcode (alu_pkg::op_t).
- busy  out  1  high during the compute cycle.
- valid  out  1  one-cycle pulse when result/flags update.
- result  out  N  registered result.
- carry  out  1  registered carry/borrow flag.
- cero  out  1  registered zero flag.
- negativo  out  1  registered sign flag (result[N-1]).
- desbordamiento  out  1  registered signed-overflow flag.
- seg  out  7  segments {g..a}, active-low.
- an  out  DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset (async, rst_n=0):
  - result=0, carry=0, cero=1, negativo=0, desbordamiento=0, busy=0, valid=0.
  - Scan counter=0, digit index=0, an=all ones except bit0=0.
- FSM states and transitions:
  - IDLE→CALC on start.
  - CALC→IDLE unconditionally.
  - In CALC: busy=1. The operation is evaluated on the captured operands. Result/flags are written at the end of CALC. valid pulses in the cycle after CALC (latency 2 clocks from start to valid).
- start while busy=1 is ignored: no capture, no queueing.
- Opcodes:
  - 0 ADD: carry = carry-out.
  - 1 SUB a-b: carry=1 on borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 SHL by b[log2 N:0]: carry = last bit shifted out; shift ≥ N gives 0.
  - 7 SHR logical, 8 SAR arithmetic: same carry and over-shift rule as SHL.
  - 9-15: result=0, all flags recomputed.
- Flags:
  - cero = (result==0).
  - negativo = result[N-1].
  - desbordamiento is set only for ADD/SUB by the two's-complement rule; it is 0 for all other ops.
  - carry is 0 for logic ops.
- Arithmetic is done in N+1 bits; the result is truncated to N.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances modulo DIGITS.
  - Digit k shows hex nibble result[4k+3:4k], zero-extended beyond N.
  - Scan runs continuously, independent of the FSM.
  - seg/an are registered; they change together on the same edge, so there is no ghosting cycle.
- Display value comes from the result register. A result update mid-scan appears on the next digit refresh; no tearing is guarded against.
- Reset asserted mid-CALC aborts the operation: outputs go to reset values and no valid pulse is issued.

Optional Feature:
- Macro: ALU_DISP_SIGNED_EN.
- When defined:
  - negativo=1 makes the display show |result| in hex.
  - The most significant digit (index DIGITS-1) shows a minus sign (only segment g lit). That digit is still scanned.
  - If DIGITS*4 ≤ N, the top nibble is replaced by the sign.
  - The most negative value shows its unsigned magnitude (e.g. N=8: 0x80 → "-80").
- When undefined: raw unsigned hex on all digits; no sign digit.

Decomposition:
- alu_pkg:
  - op_t enum (4-bit) with the opcodes above.
  - state_t {IDLE, CALC}.
  - SEG_BLANK=7'h7F and SEG_MINUS=7'h3F constants.
- One sub-module, hex_a_7seg: combinational 4-bit nibble to active-low 7-segment pattern. It is instantiated once after the digit mux.

Test Plan:
- Reset: hold rst_n=0 → result=0, cero=1, an=4'b1110, valid=0; release → scan advances one digit every SCAN_DIV clocks (use SCAN_DIV=4 in sim).
- ADD overflow (N=8): a=8'h7F, b=8'h01, op=0, start → valid 2 clocks later, result=8'h80, negativo=1, desbordamiento=1, carry=0.
- SUB borrow: a=8'h03, b=8'h05, op=1 → result=8'hFE, carry=1, negativo=1, desbordamiento=0, cero=0; ADD 8'hFF+8'h01 → result=0, carry=1, cero=1.
- Shifts: a=8'h81, b=1, op=8 (SAR) → 8'hC0, carry=1; op=6 with b=9 → result=0, carry=0, cero=1.
- Busy rule: start asserted in consecutive cycles with different operands → only the first is captured; exactly one valid pulse.
- Display: result=8'h3A, DIGITS=4 → the full scan presents segment codes for A, 3, 0, 0 on an=1110, 1101, 1011, 0111. With ALU_DISP_SIGNED_EN and result=8'hFE → digits 2, 0, 0, minus.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU with multiplexed hex display.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SAR = 4'd8
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/alu_disp_scan_if.sv
// Request/result bundle between the switch/button front end and the ALU core.
interface alu_disp_scan_if #(
    parameter int N = 8
) ();
    import alu_pkg::*;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    op_t          op;
    logic         busy;
    logic         valid;
    logic [N-1:0] result;
    logic         carry;
    logic         cero;
    logic         negativo;
    logic         desbordamiento;

    modport master (
        output start, a, b, op,
        input  busy, valid, result, carry, cero, negativo, desbordamiento
    );

    modport slave (
        input  start, a, b, op,
        output busy, valid, result, carry, cero, negativo, desbordamiento
    );

endinterface

// File: rtl/hex_a_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
module hex_a_7seg
    import alu_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (nib)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_disp_scan.sv
// Registered ALU (start -> CALC -> valid) feeding a free-running multiplexed hex display.
// Define ALU_DISP_SIGNED_EN to show negative results as a minus sign plus magnitude.
module alu_disp_scan
    import alu_pkg::*;
#(
    parameter int N        = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_disp_scan_if.slave    bus,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int SW = $clog2(N) + 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int XW = DIGITS * 4;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    op_t          op_q, op_d;
    logic         busy_q, busy_d, valid_q, valid_d;
    logic [N-1:0] result_q, result_d;
    logic         carry_q, carry_d, cero_q, cero_d;
    logic         negativo_q, negativo_d, desb_q, desb_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [6:0]    seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [N-1:0]   alu_res;
    logic           alu_c, alu_v;
    logic [N:0]     sum, diff, shl_ext, shr_ext;
    logic signed [N:0] sar_ext;
    logic [SW-1:0]  sh_amt;
    logic           over_shift;

    assign sh_amt     = b_q[SW-1:0];
    assign over_shift = (int'(sh_amt) >= N);

    // Shifts run one bit wider than N so the bit falling off the end lands in the extra position.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        shl_ext = {1'b0, a_q} << sh_amt;
        shr_ext = {a_q, 1'b0} >> sh_amt;
        sar_ext = $signed({a_q, 1'b0}) >>> sh_amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                alu_res = diff[N-1:0];
                alu_c   = diff[N];
                alu_v   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: if (!over_shift) {alu_c, alu_res} = shl_ext;
            OP_SHR: if (!over_shift) {alu_res, alu_c} = shr_ext;
            OP_SAR: if (!over_shift) {alu_res, alu_c} = sar_ext;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        busy_d     = 1'b0;
        valid_d    = 1'b0;
        result_d   = result_q;
        carry_d    = carry_q;
        cero_d     = cero_q;
        negativo_d = negativo_q;
        desb_d     = desb_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                state_d    = IDLE;
                valid_d    = 1'b1;
                result_d   = alu_res;
                carry_d    = alu_c;
                cero_d     = (alu_res == '0);
                negativo_d = alu_res[N-1];
                desb_d     = alu_v;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [N-1:0]  disp_val;
    logic [XW-1:0] disp_ext;
    logic          show_minus;
    logic [3:0]    nib_arr [DIGITS];
    logic [3:0]    nib_sel;
    logic [6:0]    hex_seg;
    logic          presc_wrap;

    always_comb begin
        presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        dig_d      = dig_q;
        if (presc_wrap) begin
            dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    always_comb begin
        disp_val   = result_q;
        show_minus = 1'b0;
`ifdef ALU_DISP_SIGNED_EN
        if (negativo_q) begin
            disp_val   = ~result_q + 1'b1;
            show_minus = (dig_d == DW'(DIGITS - 1));
        end
`endif
    end

    assign disp_ext = XW'(disp_val);

    // Segments and anodes are both derived from the next digit index so they switch on the same edge.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign nib_arr[gi] = disp_ext[gi*4 +: 4];
        assign an_d[gi]    = (dig_d != DW'(gi));
    end

    assign nib_sel = nib_arr[dig_d];

    hex_a_7seg u_hex (
        .nib   (nib_sel),
        .seg_n (hex_seg)
    );

    assign seg_d = show_minus ? SEG_MINUS : hex_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            cero_q     <= 1'b1;
            negativo_q <= 1'b0;
            desb_q     <= 1'b0;
            presc_q    <= '0;
            dig_q      <= '0;
            seg_q      <= SEG_ZERO;
            an_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            cero_q     <= cero_d;
            negativo_q <= negativo_d;
            desb_q     <= desb_d;
            presc_q    <= presc_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.valid          = valid_q;
    assign bus.result         = result_q;
    assign bus.carry          = carry_q;
    assign bus.cero           = cero_q;
    assign bus.negativo       = negativo_q;
    assign bus.desbordamiento = desb_q;
    assign seg                = seg_q;
    assign an                 = an_q;

endmodule

// File: tb/tb_alu_disp_scan.sv
// Randomized self-checking bench for alu_disp_scan against an integer-arithmetic reference model.
module tb_alu_disp_scan;
    import alu_pkg::*;

    localparam int N        = 8;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int M        = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_disp_scan_if #(.N(N)) bus ();
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    alu_disp_scan #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .seg   (seg),
        .an    (an)
    );

    int n_vec = 0;
    int n_err = 0;
    int model_res = 0;
    int edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_alu(input int ua, input int ub, input int opv,
                           output int r, output bit c, output bit v);
        int sa, sb, sh, s;
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        sh = ub % 16;
        r = 0; c = 0; v = 0;
        case (opv)
            0: begin s = ua + ub; r = s % M; c = (s >= M); v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin s = ua - ub; r = (s + M) % M; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (~ua) & (M - 1);
            6: if (sh == 0) r = ua;
               else if (sh < N) begin r = (ua << sh) % M; c = ((ua >> (N - sh)) & 1) != 0; end
            7: if (sh == 0) r = ua;
               else if (sh < N) begin r = ua >> sh; c = ((ua >> (sh - 1)) & 1) != 0; end
            8: if (sh == 0) r = ua;
               else if (sh < N) begin r = (sa >>> sh) & (M - 1); c = ((ua >> (sh - 1)) & 1) != 0; end
            default: ;
        endcase
    endtask

    function automatic logic [6:0] seg_of(input int h);
        string lit;
        logic [6:0] s;
        case (h)
            0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";   3: lit = "abcdg";
            4: lit = "bcfg";     5: lit = "acdfg";   6: lit = "acdefg";  7: lit = "abc";
            8: lit = "abcdefg";  9: lit = "abcdfg"; 10: lit = "abcefg"; 11: lit = "cdefg";
            12: lit = "adef";   13: lit = "bcdeg";  14: lit = "adefg";  default: lit = "aefg";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
        return s;
    endfunction

    function automatic logic [6:0] exp_seg(input int r, input int k);
        int v;
        v = r;
`ifdef ALU_DISP_SIGNED_EN
        if (r >= M/2) begin
            if (k == DIGITS - 1) return 7'h3F;
            v = M - r;
        end
`endif
        return seg_of((v >> (4 * k)) & 15);
    endfunction

    task automatic scan_check(input int ncyc, input int r);
        int k;
        logic [DIGITS-1:0] ea;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            k  = (edges / SCAN_DIV) % DIGITS;
            ea = ~(DIGITS'(1) << k);
            chk("an", an, ea);
            chk("seg", seg, exp_seg(r, k));
        end
    endtask

    task automatic do_op(input int av, input int bv, input int opv);
        int r;
        bit c, v;
        ref_alu(av, bv, opv, r, c, v);
        bus.a     = 8'(av);
        bus.b     = 8'(bv);
        bus.op    = op_t'(4'(opv));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy", bus.busy, 1);
        chk("valid_early", bus.valid, 0);
        @(negedge clk);
        chk("valid", bus.valid, 1);
        chk("busy_done", bus.busy, 0);
        chk("result", bus.result, r);
        chk("carry", bus.carry, c);
        chk("cero", bus.cero, (r == 0));
        chk("negativo", bus.negativo, (r >= M/2));
        chk("desbordamiento", bus.desbordamiento, v);
        model_res = r;
        $display("op=%0d a=%02h b=%02h -> result=%02h c=%0b z=%0b n=%0b v=%0b",
                 opv, av, bv, bus.result, bus.carry, bus.cero, bus.negativo, bus.desbordamiento);
        @(negedge clk);
        chk("valid_pulse", bus.valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, av, bv, opv;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = OP_ADD;
        #2 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", bus.result, 0);
        chk("rst_cero", bus.cero, 1);
        chk("rst_carry", bus.carry, 0);
        chk("rst_neg", bus.negativo, 0);
        chk("rst_ovf", bus.desbordamiento, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, seg_of(0));
        rst_n = 1'b1;
        $display("reset released");
        scan_check(20, 0);

        do_op(8'h7F, 8'h01, 0);
        do_op(8'h03, 8'h05, 1);
        do_op(8'hFF, 8'h01, 0);
        do_op(8'h81, 1, 8);
        do_op(8'hFF, 9, 6);
        do_op(8'h81, 8, 7);
        do_op(8'h55, 3, 11);

        do_op(8'h30, 8'h0A, 0);
        scan_check(16, model_res);
        do_op(8'h03, 8'h05, 1);
        scan_check(16, model_res);
        do_op(8'h7F, 8'h01, 0);
        scan_check(16, model_res);

        for (int i = 0; i < 150; i++) begin
            opv = $urandom_range(0, 15);
            av  = $urandom_range(0, 255);
            bv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            do_op(av, bv, opv);
        end

        // Back-to-back starts: the second request lands in CALC and must be dropped.
        bus.a = 8'h10; bus.b = 8'h20; bus.op = OP_ADD; bus.start = 1'b1;
        @(negedge clk);
        chk("bb_busy", bus.busy, 1);
        bus.a = 8'h55; bus.b = 8'h0F; bus.op = OP_SUB;
        @(negedge clk);
        bus.start = 1'b0;
        chk("bb_valid", bus.valid, 1);
        chk("bb_result", bus.result, 8'h30);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(bus.valid);
        end
        chk("bb_extra_valid", cnt, 0);
        chk("bb_hold", bus.result, 8'h30);
        $display("back-to-back start: result=%02h extra_valid=%0d", bus.result, cnt);
        model_res = 8'h30;

        // Reset in the middle of CALC aborts the operation.
        bus.a = 8'h12; bus.b = 8'h34; bus.op = OP_ADD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_clr", bus.busy, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_cero", bus.cero, 1);
        chk("abort_valid", bus.valid, 0);
        chk("abort_an", an, 4'b1110);
        @(negedge clk);
        rst_n = 1'b1;
        model_res = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += int'(bus.valid);
        end
        chk("abort_no_valid", cnt, 0);
        chk("abort_result_hold", bus.result, 0);
        $display("reset mid-CALC: result=%02h valid_pulses=%0d", bus.result, cnt);
        scan_check(8, model_res);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
